// File: rtl/wb_ram_arb_pkg.sv
// Shared encodings and helpers for the two-master Wishbone RAM port arbiter.
package wb_ram_arb_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StGrant0 = 3'd1,
        StGrant1 = 3'd2,
        StAbort0 = 3'd3,
        StAbort1 = 3'd4
    } arb_state_e;

    localparam bit ArbFixedPrio  = 1'b0;
    localparam bit ArbRoundRobin = 1'b1;

    // A disabled watchdog still gets a 1-bit width so declarations stay legal.
    function automatic int unsigned wdog_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_arb_select_2.sv
// Combinational next-grant selector for two requesters (round-robin or fixed priority).
module wb_arb_select_2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       rr_en_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    always_comb begin
        grant_valid_o = |req_i;
        grant_idx_o   = 1'b0;
        case (req_i)
            2'b10:   grant_idx_o = 1'b1;
            // Tie: alternate away from the last grantee, or favour master 0.
            2'b11:   grant_idx_o = rr_en_i ? ~last_grant_i : 1'b0;
            default: grant_idx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_ram_port_arbiter.sv
// Two-master to one-slave Wishbone arbiter for a shared RAM port.
// Grant is held for the whole CYC; an optional watchdog aborts stalled strobes with ERR.
module wb_ram_port_arbiter
    import wb_ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH           = 32,
    parameter int unsigned ADDR_WIDTH           = 16,
    parameter int unsigned SELECT_WIDTH         = DATA_WIDTH / 8,
    parameter bit          ARB_TYPE_ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT              = 0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    input  logic                    wbm0_cyc_i,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,

    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    input  logic                    wbm1_cyc_i,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       sel_valid, sel_idx;
    logic       arb_en;
    logic       timeout_hit;

    wb_arb_select_2 u_select (
        .req_i         ({wbm1_cyc_i, wbm0_cyc_i}),
        .last_grant_i  (last_grant_q),
        .rr_en_i       (ARB_TYPE_ROUND_ROBIN == ArbRoundRobin),
        .grant_valid_o (sel_valid),
        .grant_idx_o   (sel_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        arb_en       = 1'b0;
        unique case (state_q)
            StIdle:   arb_en = 1'b1;
            StGrant0: begin
                if (!wbm0_cyc_i)      arb_en  = 1'b1;
                else if (timeout_hit) state_d = StAbort0;
            end
            StGrant1: begin
                if (!wbm1_cyc_i)      arb_en  = 1'b1;
                else if (timeout_hit) state_d = StAbort1;
            end
            StAbort0: begin
                if (!wbm0_cyc_i) arb_en  = 1'b1;
                else             state_d = StGrant0;
            end
            StAbort1: begin
                if (!wbm1_cyc_i) arb_en  = 1'b1;
                else             state_d = StGrant1;
            end
            default:  state_d = StIdle;
        endcase
        // Handover goes straight to the next grantee, no idle bubble.
        if (arb_en) begin
            if (sel_valid) begin
                state_d      = sel_idx ? StGrant1 : StGrant0;
                last_grant_d = sel_idx;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        wbs_adr_o  = wbm0_adr_i;
        wbs_dat_o  = wbm0_dat_i;
        wbs_we_o   = wbm0_we_i;
        wbs_sel_o  = wbm0_sel_i;
        wbs_cyc_o  = 1'b0;
        wbs_stb_o  = 1'b0;
        wbm0_ack_o = 1'b0;
        wbm0_err_o = 1'b0;
        wbm1_ack_o = 1'b0;
        wbm1_err_o = 1'b0;
        unique case (state_q)
            StGrant0: begin
                wbs_cyc_o  = wbm0_cyc_i;
                wbs_stb_o  = wbm0_stb_i;
                wbm0_ack_o = wbs_ack_i;
                wbm0_err_o = wbs_err_i;
            end
            StGrant1: begin
                wbs_adr_o  = wbm1_adr_i;
                wbs_dat_o  = wbm1_dat_i;
                wbs_we_o   = wbm1_we_i;
                wbs_sel_o  = wbm1_sel_i;
                wbs_cyc_o  = wbm1_cyc_i;
                wbs_stb_o  = wbm1_stb_i;
                wbm1_ack_o = wbs_ack_i;
                wbm1_err_o = wbs_err_i;
            end
            StAbort0: wbm0_err_o = 1'b1;
            StAbort1: wbm1_err_o = 1'b1;
            default:  ;
        endcase
    end

    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;

    if (TIMEOUT > 0) begin : g_wdog
        localparam int unsigned    CntW     = wdog_cnt_width(TIMEOUT);
        localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT - 1);

        logic [CntW-1:0] cnt_q, cnt_d;
        logic            stall;

        // A same-cycle ACK/ERR clears the stall, so it always beats the abort.
        assign stall = wbs_cyc_o & wbs_stb_o & ~wbs_ack_i & ~wbs_err_i;

        always_comb begin
            cnt_d = '0;
            if (stall) cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end

        always_ff @(posedge clk) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end

        assign timeout_hit = stall & (cnt_q >= CntLimit);
    end else begin : g_no_wdog
        assign timeout_hit = 1'b0;
    end

endmodule
